// File: rtl/logic_pipe_nbit.sv
// Elastic N-stage bitwise function unit: one of seven gate functions per
// transaction, carried through STAGES valid/ready register stages with full backpressure.
module logic_pipe_nbit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             op_err,
  output logic [2:0]       count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_NAND = 3'b001,
    OP_OR   = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  logic [WIDTH-1:0]  func_result;
  logic              func_zero;
  logic              func_err;

  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_zero;
  logic [STAGES-1:0] stage_err;
  logic [WIDTH-1:0]  stage_result [STAGES];

  logic [STAGES-1:0] stage_ready;
  logic [STAGES-1:0] stage_load;
  logic [STAGES-1:0] stage_leave;
  logic [STAGES-1:0] stage_in_zero;
  logic [STAGES-1:0] stage_in_err;
  logic [WIDTH-1:0]  stage_in_result [STAGES];

  logic              accept;
  logic              emit;

  // Flags are derived here at capture so later stages only transport them.
  always_comb begin
    func_result = '0;
    func_err    = 1'b0;
    case (op)
      OP_AND:  func_result = a & b;
      OP_NAND: func_result = ~(a & b);
      OP_OR:   func_result = a | b;
      OP_NOR:  func_result = ~(a | b);
      OP_XOR:  func_result = a ^ b;
      OP_XNOR: func_result = ~(a ^ b);
      OP_NOTA: func_result = ~a;
      OP_RSVD: func_err    = 1'b1;
      default: func_err    = 1'b1;
    endcase
  end

  assign func_zero = (func_result == '0);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // A stage can take new data if out_ready is high or any stage from here
    // to the output is empty; this is the unrolled form of the ready chain.
    assign stage_ready[k] = out_ready || !(&stage_valid[STAGES-1:k]);

    if (k == 0) begin : g_first
      assign stage_load[k]      = in_valid && stage_ready[k];
      assign stage_in_result[k] = func_result;
      assign stage_in_zero[k]   = func_zero;
      assign stage_in_err[k]    = func_err;
    end else begin : g_next
      assign stage_load[k]      = stage_valid[k-1] && stage_ready[k];
      assign stage_in_result[k] = stage_result[k-1];
      assign stage_in_zero[k]   = stage_zero[k-1];
      assign stage_in_err[k]    = stage_err[k-1];
    end

    if (k == STAGES-1) begin : g_last
      assign stage_leave[k] = stage_valid[k] && out_ready;
    end else begin : g_inner
      assign stage_leave[k] = stage_valid[k] && stage_ready[k+1];
    end
  end

  // Payload registers only change on load, so the output holds its last
  // value after out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= '0;
      stage_zero  <= '0;
      stage_err   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stage_result[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (stage_load[k]) begin
          stage_valid[k]  <= 1'b1;
          stage_result[k] <= stage_in_result[k];
          stage_zero[k]   <= stage_in_zero[k];
          stage_err[k]    <= stage_in_err[k];
        end else if (stage_leave[k]) begin
          stage_valid[k]  <= 1'b0;
        end
      end
    end
  end

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 3'd0;
    end else begin
      case ({accept, emit})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  assign in_ready  = stage_ready[0];
  assign out_valid = stage_valid[STAGES-1];
  assign result    = stage_result[STAGES-1];
  assign zero      = stage_zero[STAGES-1];
  assign op_err    = stage_err[STAGES-1];

endmodule

// File: tb/tb_logic_pipe_nbit.sv
// Bench for logic_pipe_nbit: a 32-bit/2-stage and an 8-bit/1-stage instance
// share stimulus and are each compared against a FIFO-with-latency reference model.
module tb_logic_pipe_nbit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_valid0, zero0, op_err0;
  logic [2:0]  count0;
  logic [31:0] result0;
  logic        in_ready1, out_valid1, zero1, op_err1;
  logic [2:0]  count1;
  logic [7:0]  result1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        err;
    int          due;
  } txn_t;

  txn_t mq [2][8];
  int   mhead [2];
  int   msize [2];
  int   stages_m [2];
  int   width_m [2];

  always #5 clk = ~clk;

  logic_pipe_nbit #(.WIDTH(32), .STAGES(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .op(op), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
    .result(result0), .zero(zero0), .op_err(op_err0), .count(count0)
  );

  logic_pipe_nbit #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .op(op), .a(a[7:0]), .b(b[7:0]), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .zero(zero1), .op_err(op_err1), .count(count1)
  );

  // Reference gate function, masked to the instance width.
  function automatic logic [31:0] refFn(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input int w);
    logic [31:0] r;
    logic [31:0] mask;
    case (o)
      3'd0: r = x & y;
      3'd1: r = ~(x & y);
      3'd2: r = x | y;
      3'd3: r = ~(x | y);
      3'd4: r = x ^ y;
      3'd5: r = ~(x ^ y);
      3'd6: r = ~x;
      default: r = 32'h0;
    endcase
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    return r & mask;
  endfunction

  // A transaction may reach the output no sooner than STAGES-1 edges after
  // acceptance and never ahead of its predecessor.
  function automatic logic modelValid(input int d);
    return (msize[d] > 0) && (mq[d][mhead[d]].due <= cyc);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkModel(input int d);
    logic        o_ir, o_ov, o_z, o_e;
    logic [2:0]  o_cnt;
    logic [31:0] o_res;
    logic        e_ir;
    if (d == 0) begin
      o_ir = in_ready0; o_ov = out_valid0; o_z = zero0; o_e = op_err0;
      o_cnt = count0;   o_res = result0;
    end else begin
      o_ir = in_ready1; o_ov = out_valid1; o_z = zero1; o_e = op_err1;
      o_cnt = count1;   o_res = {24'h0, result1};
    end
    e_ir = (msize[d] < stages_m[d]) || out_ready;
    checkOutput($sformatf("d%0d in_ready @%0d", d, cyc), {31'h0, o_ir}, {31'h0, e_ir});
    checkOutput($sformatf("d%0d out_valid @%0d", d, cyc), {31'h0, o_ov}, {31'h0, modelValid(d)});
    checkOutput($sformatf("d%0d count @%0d", d, cyc), {29'h0, o_cnt}, msize[d]);
    if (modelValid(d)) begin
      checkOutput($sformatf("d%0d result @%0d", d, cyc), o_res, mq[d][mhead[d]].res);
      checkOutput($sformatf("d%0d zero @%0d", d, cyc), {31'h0, o_z}, {31'h0, mq[d][mhead[d]].zero});
      checkOutput($sformatf("d%0d op_err @%0d", d, cyc), {31'h0, o_e}, {31'h0, mq[d][mhead[d]].err});
    end
  endtask

  // Drives one cycle of inputs, checks both instances, then advances the
  // model across the clock edge. Entered and left at posedge+1.
  task automatic applyStimulus(input logic iv, input logic [2:0] o, input logic [31:0] aa,
                               input logic [31:0] bb, input logic ordy);
    logic acc [2];
    logic emt [2];
    txn_t t;
    in_valid = iv; op = o; a = aa; b = bb; out_ready = ordy;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkModel(d);
      acc[d] = iv && ((msize[d] < stages_m[d]) || ordy);
      emt[d] = modelValid(d) && ordy;
    end
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (emt[d]) begin
        mhead[d] = (mhead[d] + 1) % 8;
        msize[d]--;
      end
      if (acc[d]) begin
        t.res  = refFn(o, aa, bb, width_m[d]);
        t.zero = (t.res == 32'h0);
        t.err  = (o == 3'd7);
        t.due  = cyc + stages_m[d] - 1;
        mq[d][(mhead[d] + msize[d]) % 8] = t;
        msize[d]++;
      end
    end
    #1;
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mhead[d] = 0;
      msize[d] = 0;
    end
  endtask

  initial begin
    logic [31:0] sweep_exp [7];
    logic [31:0] e;
    sweep_exp[0] = 32'h88888888; sweep_exp[1] = 32'h77777777;
    sweep_exp[2] = 32'hEEEEEEEE; sweep_exp[3] = 32'h11111111;
    sweep_exp[4] = 32'h66666666; sweep_exp[5] = 32'h99999999;
    sweep_exp[6] = 32'h55555555;
    stages_m[0] = 2; width_m[0] = 32;
    stages_m[1] = 1; width_m[1] = 8;
    modelReset();

    $display("[TB] reset");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst out_valid0", {31'h0, out_valid0}, 32'h0);
    checkOutput("rst count0", {29'h0, count0}, 32'h0);
    checkOutput("rst result0", result0, 32'h0);
    checkOutput("rst zero0", {31'h0, zero0}, 32'h0);
    checkOutput("rst op_err0", {31'h0, op_err0}, 32'h0);
    checkOutput("rst out_valid1", {31'h0, out_valid1}, 32'h0);
    checkOutput("rst result1", {24'h0, result1}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single NAND");
    applyStimulus(1'b1, 3'd1, 32'hFFFF0000, 32'h0F0F0F0F, 1'b1);
    checkOutput("single count0 first", {29'h0, count0}, 32'd1);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    checkOutput("single out_valid0", {31'h0, out_valid0}, 32'h1);
    checkOutput("single result0", result0, 32'hF0F0FFFF);
    checkOutput("single zero0", {31'h0, zero0}, 32'h0);
    checkOutput("single op_err0", {31'h0, op_err0}, 32'h0);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    checkOutput("single count0 drained", {29'h0, count0}, 32'd0);

    $display("[TB] opcode sweep");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 3'(i), 32'hAAAAAAAA, 32'hCCCCCCCC, 1'b1);
      e = sweep_exp[i];
      checkOutput($sformatf("sweep8 valid op%0d", i), {31'h0, out_valid1}, 32'h1);
      checkOutput($sformatf("sweep8 result op%0d", i), {24'h0, result1}, {24'h0, e[7:0]});
      if (i > 0) begin
        checkOutput($sformatf("sweep32 result op%0d", i - 1), result0, sweep_exp[i - 1]);
      end
    end
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    checkOutput("sweep32 result op6", result0, sweep_exp[6]);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);

    $display("[TB] reserved op and zero result");
    applyStimulus(1'b1, 3'd7, 32'h12345678, $urandom, 1'b1);
    checkOutput("rsvd result1", {24'h0, result1}, 32'h0);
    checkOutput("rsvd op_err1", {31'h0, op_err1}, 32'h1);
    applyStimulus(1'b1, 3'd4, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
    checkOutput("rsvd result0", result0, 32'h0);
    checkOutput("rsvd zero0", {31'h0, zero0}, 32'h1);
    checkOutput("rsvd op_err0", {31'h0, op_err0}, 32'h1);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    checkOutput("xor result0", result0, 32'h0);
    checkOutput("xor zero0", {31'h0, zero0}, 32'h1);
    checkOutput("xor op_err0", {31'h0, op_err0}, 32'h0);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    applyStimulus(1'b1, 3'd2, 32'h0000FFFF, 32'h00FF0000, 1'b0);
    applyStimulus(1'b1, 3'd4, 32'h12345678, 32'hFFFFFFFF, 1'b0);
    checkOutput("bp in_ready0 low", {31'h0, in_ready0}, 32'h0);
    checkOutput("bp count0 full", {29'h0, count0}, 32'd2);
    checkOutput("bp result0 held", result0, 32'hF000F000);
    applyStimulus(1'b1, 3'd4, 32'h12345678, 32'hFFFFFFFF, 1'b0);
    checkOutput("bp result0 stable", result0, 32'hF000F000);
    checkOutput("bp out_valid0 stable", {31'h0, out_valid0}, 32'h1);
    applyStimulus(1'b1, 3'd4, 32'h12345678, 32'hFFFFFFFF, 1'b1);
    checkOutput("bp second result0", result0, 32'h00FFFFFF);
    checkOutput("bp count0 emit+accept", {29'h0, count0}, 32'd2);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    checkOutput("bp third result0", result0, 32'hEDCBA987);
    checkOutput("bp count0 one", {29'h0, count0}, 32'd1);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    checkOutput("bp count0 empty", {29'h0, count0}, 32'd0);

    $display("[TB] async reset mid-flight");
    applyStimulus(1'b1, 3'd2, $urandom, $urandom, 1'b0);
    applyStimulus(1'b1, 3'd5, $urandom, $urandom, 1'b0);
    checkOutput("ar count0 before", {29'h0, count0}, 32'd2);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("ar out_valid0", {31'h0, out_valid0}, 32'h0);
    checkOutput("ar count0", {29'h0, count0}, 32'd0);
    checkOutput("ar result0", result0, 32'h0);
    checkOutput("ar out_valid1", {31'h0, out_valid1}, 32'h0);
    checkOutput("ar count1", {29'h0, count1}, 32'd0);
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    checkOutput("ar no stale out_valid0", {31'h0, out_valid0}, 32'h0);

    $display("[TB] random traffic");
    repeat (400) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, rb,
                    ($urandom_range(0, 9) < 7));
    end
    repeat (6) applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
